serial_add_accum: RTL and testbench
===================================

# serial_add_accum

Parametrised multi-cycle adder/subtractor with accumulate mode, generalising the team's 4-bit ripple-carry switch adder. It processes a WIDTH-bit operation DIGIT bits per clock through a DIGIT-bit ripple slice, trading latency for area. A start/busy/done handshake controls it, and it can feed its own result back as operand A for running sums. It sits between switch/register inputs and the LED/HEX display path in lab-board designs.

## Interface
- WIDTH, 8: operand/result width in bits; must be ≥2.
- DIGIT, 1: bits processed per cycle; must divide WIDTH. S = WIDTH/DIGIT is the number of add steps.
- Clock  in  1  the single clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- start  in  1  request; sampled on a rising edge while not busy.
- a  in  WIDTH  operand A; ignored when acc=1.
- b  in  WIDTH  operand B.
- cin  in  1  carry in; ignored when sub=1.
- sub  in  1  1 = A − B (B inverted, carry in forced 1).
- acc  in  1  1 = use the current `sum` register as operand A.
- sum  out  WIDTH  registered result.
- cout  out  1  carry out of MSB; for subtraction, 1 = no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high while computing.
- done  out  1  one-cycle pulse when the result becomes valid.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1.
  - DONE: busy=0, done=1; lasts one cycle.
- IDLE or DONE, start=1 at an edge:
  - Latch operand A (`sum` if acc=1, otherwise `a`).
  - Latch B (`~b` if sub=1, otherwise `b`).
  - Load the carry register with 1 if sub=1, otherwise cin.
  - Clear the step counter and go to RUN.
- RUN, each edge:
  - Add the DIGIT LSBs of A, B and carry.
  - Shift the DIGIT sum bits into the top of the result shift register.
  - Shift A and B right by DIGIT and store the new carry.
  - Increment the step counter.
- On the edge completing step S:
  - Copy the result to `sum` and the final carry to `cout`.
  - Set `ovf` from the MSB carry-in/carry-out pair. The MSB carry-in is captured during the last step.
  - Go to DONE.
- DONE → IDLE on the next edge unless start=1, which begins a new operation (back-to-back allowed).
- start=1 during RUN is ignored; no queuing. Input changes during RUN have no effect.
- `sum`, `cout` and `ovf` change only at completion of an operation. They hold between operations.
- Arithmetic is modulo 2^WIDTH. Step-counter width is ceil(log2(S+1)).
- Combinational logic per step is one DIGIT-bit ripple slice. It reuses the full-adder cell equations: s = ci⊕a⊕b, co = majority.

## Timing
- Reset (Resetn=0 at an edge):
  - State → IDLE.
  - sum=0, cout=0, ovf=0, busy=0, done=0.
  - Internal shift registers, carry and counter are cleared.
- Reset overrides start. Reset during RUN aborts the operation; no done pulse is produced.
- Cycle 0 is the cycle in which start is high and is sampled.
  - busy=1 in cycles 1..S.
  - done=1 and the results are valid in cycle S+1.
- Latency from start edge to done is S+1 edges: DIGIT=1 → WIDTH+1; DIGIT=WIDTH → 2.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, DIGIT=1: a=0x0F, b=0x01, cin=0 → done in cycle 9; sum=0x10, cout=0, ovf=0. busy is high exactly in cycles 1–8.
- a=0x7F, b=0x01 → sum=0x80, ovf=1, cout=0. a=0xFF, b=0x01 → sum=0x00, cout=1, ovf=0.
- sub=1: a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0. Then sub=1, a=0x07, b=0x05 → sum=0x02, cout=1.
- acc=1 after reset, b=0x40, three back-to-back starts (each start in the DONE cycle):
  - sum steps 0x40 → 0x80 (ovf=1) → 0xC0.
  - Each done pulse is one cycle.
- DIGIT=4: a=0x9A, b=0x77 → sum=0x11, cout=1, done in cycle 3. Random a/b/cin/sub on DIGIT=1, 2, 4, 8 matches a reference model.
- Robustness:
  - start pulsed in cycle 4 of a run is ignored; result and latency unchanged.
  - Resetn=0 in cycle 5 → all outputs 0 next cycle and no done pulse.
  - A new start after the reset completes normally.

Source files
------------

// File: rtl/serial_add_accum.sv
// serial_add_accum: digit-serial add/subtract with accumulate, start/busy/done handshake.
// One DIGIT-bit ripple slice per clock; S = WIDTH/DIGIT steps per operation.
module serial_add_accum #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             i_clock,
   input  logic             i_resetn,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   input  logic             i_sub,
   input  logic             i_acc,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout,
   output logic             o_ovf,
   output logic             o_busy,
   output logic             o_done
);
   localparam int S  = WIDTH / DIGIT;
   localparam int CW = $clog2(S + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_a, r_b, r_res, r_sum, w_res_n;
   logic             r_c, r_cout, r_ovf;
   logic [CW-1:0]    r_cnt;
   logic [DIGIT:0]   w_c;
   logic [DIGIT-1:0] w_s;
   logic             w_load, w_last;
   assign w_c[0] = r_c;
   genvar i;
   for (i = 0; i < DIGIT; i++) begin : g_fa
      assign w_s[i]   = w_c[i] ^ r_a[i] ^ r_b[i];
      assign w_c[i+1] = (r_a[i] & r_b[i]) | (r_a[i] & w_c[i]) | (r_b[i] & w_c[i]);
   end
   // Sum digits enter at the top so the LSB digit lands at bit 0 after S steps.
   assign w_res_n = (r_res >> DIGIT) | (WIDTH'(w_s) << (WIDTH - DIGIT));
   assign w_load  = i_start && (r_state != RUN);
   assign w_last  = (r_state == RUN) && (r_cnt == CW'(S - 1));
   always_ff @(posedge i_clock) begin
      if (!i_resetn) r_state <= IDLE;
      else r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_load ? RUN : IDLE;
         RUN:     w_next = w_last ? DONE : RUN;
         DONE:    w_next = w_load ? RUN : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge i_clock) begin
      if (!i_resetn) begin
         r_a    <= '0;
         r_b    <= '0;
         r_res  <= '0;
         r_c    <= 1'b0;
         r_cnt  <= '0;
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_load) begin
         r_a   <= i_acc ? r_sum : i_a;
         r_b   <= i_sub ? ~i_b : i_b;
         r_c   <= i_sub | i_cin;
         r_res <= '0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_a   <= r_a >> DIGIT;
         r_b   <= r_b >> DIGIT;
         r_c   <= w_c[DIGIT];
         r_res <= w_res_n;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_sum  <= w_res_n;
            r_cout <= w_c[DIGIT];
            r_ovf  <= w_c[DIGIT] ^ w_c[DIGIT-1];
         end
      end
   end
   assign o_sum  = r_sum;
   assign o_cout = r_cout;
   assign o_ovf  = r_ovf;
   assign o_busy = (r_state == RUN);
   assign o_done = (r_state == DONE);
endmodule

// File: tb/tb_serial_add_accum.sv
// tb_serial_add_accum: four instances (DIGIT=1,2,4,8) driven in parallel, checked against
// a per-instance scoreboard plus a table of hand-computed vectors and corner sequences.
module tb_serial_add_accum;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic       resetn, start, cin, sub, acc;
   logic [7:0] a, b;
   logic [7:0] sum[4];
   logic       cout[4], ovf[4], busy[4], done[4], pdone[4];
   genvar g;
   for (g = 0; g < 4; g++) begin : g_dut
      serial_add_accum #(.WIDTH(8), .DIGIT(1 << g)) u (
         .i_clock(clk), .i_resetn(resetn), .i_start(start), .i_a(a), .i_b(b),
         .i_cin(cin), .i_sub(sub), .i_acc(acc), .o_sum(sum[g]), .o_cout(cout[g]),
         .o_ovf(ovf[g]), .o_busy(busy[g]), .o_done(done[g]));
   end
   typedef struct {logic [7:0] sum; logic cout; logic ovf; int t0;} exp_t;
   typedef struct {logic [7:0] a, b; logic cin, sub; logic [7:0] sum; logic cout, ovf;} vec_t;
   exp_t       sbq[4][$];
   logic [7:0] msum[4];
   int         n_cmp = 0, n_fail = 0, tcnt = 0;
   always @(posedge clk) tcnt <= tcnt + 1;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   function automatic exp_t model(input logic [7:0] aa, bb, input logic ci, s);
      logic [7:0] bx;
      logic [8:0] r;
      exp_t       e;
      bx     = s ? ~bb : bb;
      r      = {1'b0, aa} + {1'b0, bx} + {8'd0, s | ci};
      e.sum  = r[7:0];
      e.cout = r[8];
      e.ovf  = (aa[7] == bx[7]) && (r[7] != aa[7]);
      e.t0   = tcnt;
      return e;
   endfunction
   // Scoreboard: each done pulse pops the oldest expectation of that instance.
   always @(negedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (done[k]) begin
            chk($sformatf("done_width[%0d]", k), 32'(pdone[k]), 0);
            chk($sformatf("sb_pending[%0d]", k), 32'(sbq[k].size() != 0), 1);
            if (sbq[k].size() != 0) begin
               chk($sformatf("sb_result[%0d]", k), {sum[k], cout[k], ovf[k]},
                   {sbq[k][0].sum, sbq[k][0].cout, sbq[k][0].ovf});
               chk($sformatf("latency[%0d]", k), tcnt - sbq[k][0].t0, (8 >> k) + 1);
               void'(sbq[k].pop_front());
            end
         end
         pdone[k] <= done[k];
      end
   end
   task automatic launch(input logic [7:0] ia, ib, input logic icin, isub, iacc);
      exp_t e;
      a = ia; b = ib; cin = icin; sub = isub; acc = iacc; start = 1'b1;
      for (int k = 0; k < 4; k++)
         if (!busy[k]) begin
            e = model(iacc ? msum[k] : ia, ib, icin, isub);
            sbq[k].push_back(e);
            msum[k] = e.sum;
         end
      @(negedge clk);
      start = 1'b0;
   endtask
   function automatic int qtot();
      int t = 0;
      for (int k = 0; k < 4; k++) t += sbq[k].size();
      return t;
   endfunction
   task automatic wait_idle();
      for (int i = 0; i < 40 && qtot() != 0; i++) @(negedge clk);
      chk("idle_timeout", qtot(), 0);
   endtask
   task automatic wait_done0();
      for (int i = 0; i < 20 && !done[0]; i++) @(negedge clk);
      chk("done0_seen", 32'(done[0]), 1);
   endtask
   task automatic chk_zero(input string nm);
      for (int k = 0; k < 4; k++)
         chk($sformatf("%s[%0d]", nm, k), {sum[k], cout[k], ovf[k], busy[k], done[k]}, 0);
   endtask
   initial begin
      vec_t       tv[6];
      logic [8:0] mask;
      logic [8:0] acc_exp[3];
      int         nd;
      tv[0] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
      tv[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      tv[2] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      tv[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
      tv[4] = '{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
      tv[5] = '{8'h9A, 8'h77, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0};
      acc_exp[0] = {8'h40, 1'b0};
      acc_exp[1] = {8'h80, 1'b1};
      acc_exp[2] = {8'hC0, 1'b0};
      resetn = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; acc = 1'b0;
      for (int k = 0; k < 4; k++) msum[k] = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset_state");
      resetn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         launch(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 1'b0);
         for (int c = 1; c <= 9; c++) begin
            mask[c-1] = busy[0];
            @(negedge clk);
         end
         chk($sformatf("busy_cycles_v%0d", i), mask, 9'h0FF);
         wait_idle();
         for (int k = 0; k < 4; k++)
            chk($sformatf("vec%0d[%0d]", i, k), {sum[k], cout[k], ovf[k]},
                {tv[i].sum, tv[i].cout, tv[i].ovf});
      end
      // start in cycle 4 of a DIGIT=1 run must be ignored
      launch(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      launch(8'hAA, 8'h55, 1'b1, 1'b0, 1'b0);
      wait_idle();
      chk("ignored_start_sum", {sum[0], cout[0], ovf[0]}, {8'h10, 1'b0, 1'b0});
      // reset in cycle 5 aborts the run
      launch(8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      chk_zero("abort_reset");
      for (int k = 0; k < 4; k++) begin
         sbq[k].delete();
         msum[k] = '0;
      end
      resetn = 1'b1;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         nd += int'(done[0]);
      end
      chk("no_done_after_abort", nd, 0);
      // back-to-back accumulate, each start in the DONE cycle
      for (int i = 0; i < 3; i++) begin
         launch(8'h00, 8'h40, 1'b0, 1'b0, 1'b1);
         wait_done0();
         chk($sformatf("acc_step%0d", i), {sum[0], ovf[0]}, acc_exp[i]);
      end
      wait_idle();
      for (int i = 0; i < 40; i++) begin
         launch(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         wait_idle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
